// File: rtl/nav_arb.sv
// nav_arb: round-robin arbiter and sequencer for the navigation unit's heading/move port.
// Define NAV_ARB_TMO_EN to build the BUSY timeout (timer, terminal-count abort, tmo_err).

module nav_arb #(
  parameter int unsigned HDNG_W = 12,
  parameter int unsigned TMO_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h_req,
  input  logic              h_mv,
  input  logic [HDNG_W-1:0] h_hdng,
  output logic              h_done,
  input  logic              s_req,
  input  logic              s_mv,
  input  logic [HDNG_W-1:0] s_hdng,
  output logic              s_done,
  output logic              strt_hdng,
  output logic              strt_mv,
  output logic [HDNG_W-1:0] dsrd_hdng,
  input  logic              mv_cmplt,
  output logic              tmo_err,
  output logic              ovf
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  typedef logic [TMO_W-1:0] tmo_cnt_t;

  localparam logic OWN_H = 1'b0;
  localparam logic OWN_S = 1'b1;

  state_t              state_r;
  state_t              state_nxt_s;

  logic                h_vld_r;
  logic                h_mv_r;
  logic [HDNG_W-1:0]   h_hdng_r;
  logic                s_vld_r;
  logic                s_mv_r;
  logic [HDNG_W-1:0]   s_hdng_r;

  logic                last_gnt_r;
  logic                op_own_r;
  logic                op_mv_r;
  logic [HDNG_W-1:0]   dsrd_hdng_r;

  logic                strt_hdng_r;
  logic                strt_mv_r;
  logic                h_done_r;
  logic                s_done_r;
  logic                ovf_r;

  logic                gnt_s;
  logic                gnt_own_s;
  logic                win_mv_s;
  logic [HDNG_W-1:0]   win_hdng_s;
  logic                h_gnt_s;
  logic                s_gnt_s;
  logic                h_drop_s;
  logic                s_drop_s;
  logic                finish_s;
  logic                tmo_tc_s;

  // Arbiter: grants only from IDLE, and not while a done pulse is still out, so the next
  // queued command starts three cycles after the completing mv_cmplt.
  always_comb begin
    gnt_s     = 1'b0;
    gnt_own_s = OWN_H;
    if ((state_r == ST_IDLE) && !h_done_r && !s_done_r) begin
      if (h_vld_r && s_vld_r) begin
        gnt_s     = 1'b1;
        gnt_own_s = (last_gnt_r == OWN_H) ? OWN_S : OWN_H;
      end else if (h_vld_r) begin
        gnt_s     = 1'b1;
        gnt_own_s = OWN_H;
      end else if (s_vld_r) begin
        gnt_s     = 1'b1;
        gnt_own_s = OWN_S;
      end else begin
        gnt_s     = 1'b0;
        gnt_own_s = OWN_H;
      end
    end else begin
      gnt_s     = 1'b0;
      gnt_own_s = OWN_H;
    end
  end

  assign h_gnt_s    = gnt_s && (gnt_own_s == OWN_H);
  assign s_gnt_s    = gnt_s && (gnt_own_s == OWN_S);
  assign win_mv_s   = (gnt_own_s == OWN_S) ? s_mv_r : h_mv_r;
  assign win_hdng_s = (gnt_own_s == OWN_S) ? s_hdng_r : h_hdng_r;
  assign h_drop_s   = h_req && h_vld_r && !h_gnt_s;
  assign s_drop_s   = s_req && s_vld_r && !s_gnt_s;

  // Next-state decode; completion takes priority over a simultaneous terminal count.
  always_comb begin
    state_nxt_s = state_r;
    finish_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (gnt_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_nxt_s = ST_BUSY;
      end
      ST_BUSY: begin
        if (mv_cmplt) begin
          finish_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (tmo_tc_s) begin
          finish_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Pending slots: a request on the grant edge refills the slot instead of overflowing.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_vld_r  <= 1'b0;
      h_mv_r   <= 1'b0;
      h_hdng_r <= {HDNG_W{1'b0}};
      s_vld_r  <= 1'b0;
      s_mv_r   <= 1'b0;
      s_hdng_r <= {HDNG_W{1'b0}};
    end else begin
      if (h_req && !h_drop_s) begin
        h_vld_r  <= 1'b1;
        h_mv_r   <= h_mv;
        h_hdng_r <= h_hdng;
      end else if (h_gnt_s) begin
        h_vld_r  <= 1'b0;
      end
      if (s_req && !s_drop_s) begin
        s_vld_r  <= 1'b1;
        s_mv_r   <= s_mv;
        s_hdng_r <= s_hdng;
      end else if (s_gnt_s) begin
        s_vld_r  <= 1'b0;
      end
    end
  end

  // Operation registers, captured on the grant edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_r  <= OWN_S;
      op_own_r    <= OWN_H;
      op_mv_r     <= 1'b0;
      dsrd_hdng_r <= {HDNG_W{1'b0}};
    end else if (gnt_s) begin
      last_gnt_r  <= gnt_own_s;
      op_own_r    <= gnt_own_s;
      op_mv_r     <= win_mv_s;
      dsrd_hdng_r <= win_hdng_s;
    end
  end

  // Registered output pulses: start lands in ISSUE, done in the first IDLE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      strt_hdng_r <= 1'b0;
      strt_mv_r   <= 1'b0;
      h_done_r    <= 1'b0;
      s_done_r    <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      strt_hdng_r <= gnt_s && !win_mv_s;
      strt_mv_r   <= gnt_s && win_mv_s;
      h_done_r    <= finish_s && (op_own_r == OWN_H);
      s_done_r    <= finish_s && (op_own_r == OWN_S);
      ovf_r       <= ovf_r || h_drop_s || s_drop_s;
    end
  end

`ifdef NAV_ARB_TMO_EN
  tmo_cnt_t timer_r;
  logic     tmo_err_r;

  // BUSY timer: cleared in ISSUE, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_r <= {TMO_W{1'b0}};
    end else if (state_r == ST_ISSUE) begin
      timer_r <= {TMO_W{1'b0}};
    end else if ((state_r == ST_BUSY) && (timer_r != {TMO_W{1'b1}})) begin
      timer_r <= timer_r + TMO_W'(1);
    end
  end

  assign tmo_tc_s = (state_r == ST_BUSY) && (timer_r == {TMO_W{1'b1}});

  // Timeout pulse, suppressed when mv_cmplt arrives on the terminal-count cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_err_r <= 1'b0;
    end else begin
      tmo_err_r <= tmo_tc_s && !mv_cmplt;
    end
  end

  assign tmo_err = tmo_err_r;
`else
  assign tmo_tc_s = 1'b0;
  assign tmo_err  = 1'b0;
`endif

  assign strt_hdng = strt_hdng_r;
  assign strt_mv   = strt_mv_r;
  assign dsrd_hdng = dsrd_hdng_r;
  assign h_done    = h_done_r;
  assign s_done    = s_done_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_nav_arb.sv
// Self-checking bench for nav_arb: per-cycle vector table plus hand-written timeout/reset runs.
// Each record gives one cycle's inputs and the outputs expected in that same cycle.

module tb_nav_arb;

  localparam int HW = 12;
  localparam int TW = 4;

  logic          clk;
  logic          rst;
  logic          h_req, h_mv, s_req, s_mv, mv_cmplt;
  logic [HW-1:0] h_hdng, s_hdng;
  logic          h_done, s_done, strt_hdng, strt_mv, tmo_err, ovf;
  logic [HW-1:0] dsrd_hdng;

  int checks;
  int errors;

  nav_arb #(.HDNG_W(HW), .TMO_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .h_req     (h_req),
    .h_mv      (h_mv),
    .h_hdng    (h_hdng),
    .h_done    (h_done),
    .s_req     (s_req),
    .s_mv      (s_mv),
    .s_hdng    (s_hdng),
    .s_done    (s_done),
    .strt_hdng (strt_hdng),
    .strt_mv   (strt_mv),
    .dsrd_hdng (dsrd_hdng),
    .mv_cmplt  (mv_cmplt),
    .tmo_err   (tmo_err),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          r;
    logic          hr;
    logic          hm;
    logic [HW-1:0] hh;
    logic          sr;
    logic          sm;
    logic [HW-1:0] sh;
    logic          mc;
    int            n;
    logic          e_sh;
    logic          e_sm;
    logic [HW-1:0] e_dh;
    logic          e_hd;
    logic          e_sd;
    logic          e_tmo;
    logic          e_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic hr, input logic hm, input logic [HW-1:0] hh,
                              input logic sr, input logic sm, input logic [HW-1:0] sh, input logic mc,
                              input int n, input logic e_sh, input logic e_sm, input logic [HW-1:0] e_dh,
                              input logic e_hd, input logic e_sd, input logic e_tmo, input logic e_ovf);
    vec_t v;
    v.r = r; v.hr = hr; v.hm = hm; v.hh = hh; v.sr = sr; v.sm = sm; v.sh = sh; v.mc = mc; v.n = n;
    v.e_sh = e_sh; v.e_sm = e_sm; v.e_dh = e_dh; v.e_hd = e_hd; v.e_sd = e_sd;
    v.e_tmo = e_tmo; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string nm, input int id, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h want %h", nm, id, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    for (int k = 0; k < v.n; k++) begin
      @(posedge clk);
      #1;
      rst = v.r; h_req = v.hr; h_mv = v.hm; h_hdng = v.hh;
      s_req = v.sr; s_mv = v.sm; s_hdng = v.sh; mv_cmplt = v.mc;
      chk("strt_hdng", id, HW'(strt_hdng), HW'(v.e_sh));
      chk("strt_mv",   id, HW'(strt_mv),   HW'(v.e_sm));
      chk("dsrd_hdng", id, dsrd_hdng,      v.e_dh);
      chk("h_done",    id, HW'(h_done),    HW'(v.e_hd));
      chk("s_done",    id, HW'(s_done),    HW'(v.e_sd));
      chk("tmo_err",   id, HW'(tmo_err),   HW'(v.e_tmo));
      chk("ovf",       id, HW'(ovf),       HW'(v.e_ovf));
    end
  endtask

  logic [HW-1:0] pd;
  int            id;

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; h_req = 1'b0; h_mv = 1'b0; h_hdng = '0; s_req = 1'b0; s_mv = 1'b0; s_hdng = '0;
    mv_cmplt = 1'b0;
    repeat (2) @(posedge clk);

    //                r  hr hm hh       sr sm sh       mc n   sh sm dh       hd sd to ov
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h000, 0, 0, 0, 0));
    // tie after reset: H first, then S
    tbl.push_back(mk(0, 1, 0, 12'h7FF, 1, 0, 12'hC00, 0, 1, 0, 0, 12'h000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 1, 0, 12'h7FF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 2, 0, 0, 12'h7FF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 1, 0, 0, 12'h7FF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h7FF, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h7FF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 1, 0, 12'hC00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'hC00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 1, 0, 0, 12'hC00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'hC00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'hC00, 0, 0, 0, 0));
    // lone host move, leaves last grant at H
    tbl.push_back(mk(0, 1, 1, 12'h123, 0, 0, 12'h000, 0, 1, 0, 0, 12'hC00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'hC00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 1, 12'h123, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 1, 0, 0, 12'h123, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h123, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h123, 0, 0, 0, 0));
    // second tie: S wins this time
    tbl.push_back(mk(0, 1, 0, 12'h0AA, 1, 1, 12'h055, 0, 1, 0, 0, 12'h123, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h123, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 1, 12'h055, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 1, 0, 0, 12'h055, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h055, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h055, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 1, 0, 12'h0AA, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 1, 0, 0, 12'h0AA, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h0AA, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h0AA, 0, 0, 0, 0));
    // overflow: two extra S requests while S pending and H busy, then re-request on grant edge
    tbl.push_back(mk(0, 1, 1, 12'h111, 0, 0, 12'h000, 0, 1, 0, 0, 12'h0AA, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 1, 0, 12'h222, 0, 1, 0, 0, 12'h0AA, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 1, 0, 12'h333, 0, 1, 0, 1, 12'h111, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 1, 0, 12'h444, 0, 1, 0, 0, 12'h111, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 1, 0, 0, 12'h111, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h111, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 12'h000, 1, 1, 12'h555, 0, 1, 0, 0, 12'h111, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 1, 0, 12'h222, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 1, 0, 0, 12'h222, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h222, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h222, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 1, 12'h555, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 1, 0, 0, 12'h555, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h555, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h555, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h555, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h000, 0, 0, 0, 0));
    // spurious completions in IDLE and ISSUE; grant-edge re-request keeps ovf clear
    tbl.push_back(mk(0, 1, 0, 12'h0F0, 0, 0, 12'h000, 1, 1, 0, 0, 12'h000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 12'h0F1, 0, 0, 12'h000, 1, 1, 0, 0, 12'h000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 1, 1, 0, 12'h0F0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 3, 0, 0, 12'h0F0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 1, 0, 0, 12'h0F0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h0F0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h0F0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 1, 12'h0F1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 1, 0, 0, 12'h0F1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h0F1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 12'h0F1, 0, 0, 0, 0));

    foreach (tbl[i]) apply(tbl[i], i);
    id = 100;

`ifdef NAV_ARB_TMO_EN
    // timeout after 16 BUSY cycles, then mv_cmplt on the 16th cycle counts as completion
    apply(mk(0, 1, 1, 12'hABC, 0, 0, 12'h000, 0, 1,  0, 0, 12'h0F1, 0, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1,  0, 0, 12'h0F1, 0, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1,  0, 1, 12'hABC, 0, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 16, 0, 0, 12'hABC, 0, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1,  0, 0, 12'hABC, 1, 0, 1, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1,  0, 0, 12'hABC, 0, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 1, 0, 12'hDEF, 0, 1,  0, 0, 12'hABC, 0, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1,  0, 0, 12'hABC, 0, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1,  1, 0, 12'hDEF, 0, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 15, 0, 0, 12'hDEF, 0, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 1,  0, 0, 12'hDEF, 0, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1,  0, 0, 12'hDEF, 0, 1, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1,  0, 0, 12'hDEF, 0, 0, 0, 0), id++);
    pd = 12'hDEF;
`else
    // no timeout: BUSY holds well past 16 cycles until mv_cmplt
    apply(mk(0, 1, 1, 12'hABC, 0, 0, 12'h000, 0, 1,  0, 0, 12'h0F1, 0, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1,  0, 0, 12'h0F1, 0, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1,  0, 1, 12'hABC, 0, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 24, 0, 0, 12'hABC, 0, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 1,  0, 0, 12'hABC, 0, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1,  0, 0, 12'hABC, 1, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1,  0, 0, 12'hABC, 0, 0, 0, 0), id++);
    pd = 12'hABC;
`endif

    // reset mid-BUSY with S pending: nothing survives the reset
    apply(mk(0, 1, 1, 12'h321, 0, 0, 12'h000, 0, 1,  0, 0, pd,      0, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 1, 0, 12'h654, 0, 1,  0, 0, pd,      0, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1,  0, 1, 12'h321, 0, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 2,  0, 0, 12'h321, 0, 0, 0, 0), id++);
    apply(mk(1, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1,  0, 0, 12'h321, 0, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1,  0, 0, 12'h000, 0, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 1,  0, 0, 12'h000, 0, 0, 0, 0), id++);
    apply(mk(0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 20, 0, 0, 12'h000, 0, 0, 0, 0), id++);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
